// File: rtl/lvt_ram_nrnw.sv
// lvt_ram_nrnw: NR-read / NW-write RAM built from replicated 1R1W banks.
// A live-value table remembers which write port last wrote each address.
// After reset a sequencer zeroes every bank and the LVT before accepting writes.
//
//   state | meaning
//   INIT  | clearing banks and LVT one address per clock, writes ignored
//   RUN   | normal operation, ready high
module lvt_ram_nrnw #(
  parameter int NR     = 2,
  parameter int NW     = 2,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int BYPASS = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NW*ADDR_W-1:0]   w_addr,
  input  logic [NW*DATA_W-1:0]   w_din,
  input  logic [NW-1:0]          w_enb,
  input  logic [NR*ADDR_W-1:0]   r_addr,
  output logic [NR*DATA_W-1:0]   r_dout,
  output logic                   ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LW    = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         clr_cnt_q;
  logic                      clr_en, wr_en;
  logic [LW-1:0]             lvt_q [DEPTH];
  logic [NW*NR*DATA_W-1:0]   bank_rd;
  logic [NR*DATA_W-1:0]      rd_d;
  logic [NR*DATA_W-1:0]      r_dout_q;

  // State register; reset always restarts the clearing sequence
  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  // Next state: leave INIT once the last address has been cleared
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    clr_en = (state_q == INIT);
    wr_en  = (state_q == RUN);
    ready  = (state_q == RUN);
  end

  // Clear address counter, wraps back to zero as INIT finishes
  always_ff @(posedge clk) begin
    if (rst)         clr_cnt_q <= '0;
    else if (clr_en) clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
  end

  // LVT update; later loop iterations override, so the highest port wins a collision
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en) begin
        lvt_q[clr_cnt_q] <= '0;
      end else if (wr_en) begin
        for (int w = 0; w < NW; w++) begin
          if (w_enb[w]) lvt_q[w_addr[w*ADDR_W +: ADDR_W]] <= LW'(w);
        end
      end
    end
  end

  for (genvar w = 0; w < NW; w++) begin : g_w
    for (genvar r = 0; r < NR; r++) begin : g_r
      logic [DATA_W-1:0] mem_q [DEPTH];

      // Bank [w][r]: zeroed during INIT, written only by port w in RUN
      always_ff @(posedge clk) begin
        if (!rst) begin
          if (clr_en)
            mem_q[clr_cnt_q] <= '0;
          else if (wr_en && w_enb[w])
            mem_q[w_addr[w*ADDR_W +: ADDR_W]] <= w_din[w*DATA_W +: DATA_W];
        end
      end

      assign bank_rd[(w*NR+r)*DATA_W +: DATA_W] = mem_q[r_addr[r*ADDR_W +: ADDR_W]];
    end
  end

  // Read select by LVT owner, optionally overridden by a same-cycle write
  always_comb begin
    rd_d = '0;
    for (int r = 0; r < NR; r++) begin
      for (int w = 0; w < NW; w++) begin
        if (lvt_q[r_addr[r*ADDR_W +: ADDR_W]] == LW'(w))
          rd_d[r*DATA_W +: DATA_W] = bank_rd[(w*NR+r)*DATA_W +: DATA_W];
      end
      if (BYPASS != 0) begin
        for (int w = 0; w < NW; w++) begin
          if (w_enb[w] && (w_addr[w*ADDR_W +: ADDR_W] == r_addr[r*ADDR_W +: ADDR_W]))
            rd_d[r*DATA_W +: DATA_W] = w_din[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Registered read data, forced to zero outside RUN
  always_ff @(posedge clk) begin
    if (rst)        r_dout_q <= '0;
    else if (wr_en) r_dout_q <= rd_d;
    else            r_dout_q <= '0;
  end

  assign r_dout = r_dout_q;

endmodule

// File: doc/lvt_ram_nrnw.md
Name: lvt_ram_nrnw

Overview:
Parametrised multi-port RAM with NR read ports and NW write ports, built with the Live-Value-Table (LVT) method. It generalises the fixed 2R2W LVT RAM. Storage is NW×NR replicated 1R1W banks, and a register-based LVT records which write port last wrote each address. It adds configurable write-to-read bypass and a reset-time clearing sequencer that zeroes all banks and the LVT, so reads after reset return defined data.

Parameters:
NR, 2, number of read ports (>=1)
NW, 2, number of write ports (>=1)
ADDR_W, 11, address width; DEPTH = 2**ADDR_W
DATA_W, 32, data width
BYPASS, 0, 0 = read-before-write on same-cycle collision, 1 = write-through (new data)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
w_addr  in  NW*ADDR_W  write addresses, port w at bits [w*ADDR_W +: ADDR_W]
w_din  in  NW*DATA_W  write data, port w at [w*DATA_W +: DATA_W]
w_enb  in  NW  write enables, bit w for port w
r_addr  in  NR*ADDR_W  read addresses, port r at [r*ADDR_W +: ADDR_W]
r_dout  out  NR*DATA_W  registered read data, port r at [r*DATA_W +: DATA_W]
ready  out  1  high once clearing completes; writes are accepted only while high

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- Storage: bank[w][r] holds DEPTH×DATA_W. Write port w writes all banks bank[w][0..NR-1]. Read port r reads bank[0..NW-1][r].
- LVT holds DEPTH entries of LW = max(1, clog2(NW)) bits each.
- State machine has two states, INIT and RUN.
- Reset: rst=1 at an edge sets state=INIT, clr_cnt=0, ready=0, and all r_dout=0. rst dominates every other input.
- INIT, each edge with rst=0:
  - Writes 0 to address clr_cnt in every bank.
  - Writes LVT[clr_cnt]=0.
  - Increments clr_cnt.
  - At clr_cnt=DEPTH-1 the state goes to RUN, and ready=1 after that edge. ready therefore rises DEPTH edges after rst falls.
- During INIT, w_enb is ignored and r_dout is held at 0.
- rst asserted during INIT restarts clearing from 0. rst asserted during RUN returns to INIT; ready falls at that edge.
- Write (RUN): at an edge with w_enb[w]=1, bank[w][*][w_addr_w] <= w_din_w and LVT[w_addr_w] <= w.
- Write collision: several enabled ports with equal addresses → the highest port index wins the LVT entry. Its data is the value read thereafter. Losing ports still write their own banks, which is harmless.
- Read: r_dout is registered. At edge k, r_dout_r <= bank[LVT[a]][r][a], where a = r_addr_r sampled at edge k. Read latency is 1 clock.
- Same-edge read/write to address a:
  - BYPASS=0 → r_dout gets the pre-write value.
  - BYPASS=1 → r_dout gets w_din of the winning (highest-index) enabled port writing a.
- Reads in RUN are unconditional; there is no read enable. Multiple read ports may read the same address in the same cycle.
- All addresses are in range by width; there is no wrap logic. NW=1 degenerates to an NR-bank replicated RAM with LVT width 1, constant 0.

Test Plan:
1. Defaults: pulse rst 1 cycle, then idle → ready=0 for exactly 2048 edges then 1. Reads of 0x000, 0x3FF, 0x7FF on both ports return 0x00000000.
2. RUN: same cycle, port0 writes 0x00A=0x12345678 and port1 writes 0x005=0xDEADBEEF. Next cycle r1_addr=0x005, r2_addr=0x00A → one edge later d1=0xDEADBEEF, d2=0x12345678.
3. Collision: both ports write 0x010, port0 0xAAAA0000 and port1 0x5555FFFF → both read ports at 0x010 return 0x5555FFFF.
4. Alternating ownership at address 0x003: port0 writes 1, port1 writes 2, port0 writes 3, on consecutive cycles. Reading after each write returns 1, 2, 3; the LVT follows the last writer.
5. Same-cycle read/write at 0x020: old value 0x11, new value 0x22. BYPASS=0 → r_dout=0x11; BYPASS=1 → r_dout=0x22. The next read returns 0x22 in both modes.
6. Write 0x7FF=0xCAFEF00D in RUN, assert rst for 1 cycle, then attempt a write during INIT at 0x100=0x1 → after ready rises, 0x7FF and 0x100 both read 0x00000000. Asserting rst again mid-INIT at clr_cnt=500 → ready rises 2048 edges after the second rst falls.
